// File: rtl/xbar_voq_core.sv
// Channel-to-bank request crossbar: one VOQ per (channel, bank) pair, a
// round-robin arbiter and a registered output stage per bank.
module xbar_voq_core #(
  parameter int N_CH     = 3,
  parameter int N_BANK   = 4,
  parameter int DEPTH    = 8,
  parameter int REQ_W    = 64,
  parameter int BANK_LSB = 6,
  parameter int WBUF_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          u_req_valid,
  output logic [N_CH-1:0]          u_req_ready,
  input  logic [N_CH*REQ_W-1:0]    u_req,
  input  logic [N_CH*WBUF_W-1:0]   u_req_wbuf_id,
  output logic [N_BANK-1:0]        d_req_valid,
  input  logic [N_BANK-1:0]        d_req_ready,
  output logic [N_BANK*REQ_W-1:0]  d_req,
  output logic [N_BANK*WBUF_W-1:0] d_req_wbuf_id,
  output logic [N_BANK*N_CH-1:0]   d_req_ch_1hot,
  output logic                     idle
);

  localparam int BW    = $clog2(N_BANK);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int CW    = $clog2(N_CH);
  localparam int EW    = REQ_W + WBUF_W;

  logic [EW-1:0]    mem_reg    [N_CH][N_BANK][DEPTH];
  logic [PW-1:0]    wr_ptr_reg [N_CH][N_BANK];
  logic [PW-1:0]    rd_ptr_reg [N_CH][N_BANK];
  logic [CNT_W-1:0] count_reg  [N_CH][N_BANK];
  logic [BW-1:0]    bsel       [N_CH];
  logic [N_CH-1:0]  push;
  logic [N_BANK*N_CH-1:0] pop_flat;

  // Ready looks only at the VOQ the payload steers to, never at valid.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign bsel[gi]        = u_req[gi*REQ_W + BANK_LSB +: BW];
    assign u_req_ready[gi] = !rst && (count_reg[gi][bsel[gi]] != CNT_W'(DEPTH));
    assign push[gi]        = u_req_valid[gi] && u_req_ready[gi];
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push[c]) begin
        mem_reg[c][bsel[c]][wr_ptr_reg[c][bsel[c]]] <=
          {u_req[c*REQ_W +: REQ_W], u_req_wbuf_id[c*WBUF_W +: WBUF_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int b = 0; b < N_BANK; b++) begin
          wr_ptr_reg[c][b] <= '0;
          rd_ptr_reg[c][b] <= '0;
          count_reg[c][b]  <= '0;
        end
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        for (int b = 0; b < N_BANK; b++) begin
          if (push[c] && (bsel[c] == BW'(b))) begin
            wr_ptr_reg[c][b] <= wr_ptr_reg[c][b] + 1'b1;
          end
          if (pop_flat[b*N_CH + c]) begin
            rd_ptr_reg[c][b] <= rd_ptr_reg[c][b] + 1'b1;
          end
          count_reg[c][b] <= count_reg[c][b]
                             + CNT_W'(push[c] && (bsel[c] == BW'(b)))
                             - CNT_W'(pop_flat[b*N_CH + c]);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_BANK; gi++) begin : g_bank
    logic [CW-1:0]   rr_ptr_reg;
    logic [CW-1:0]   win;
    logic [CW-1:0]   idx;
    logic            found;
    logic            load;
    logic [EW-1:0]   head;
    logic            valid_reg;
    logic [REQ_W-1:0]  data_reg;
    logic [WBUF_W-1:0] wbuf_reg;
    logic [N_CH-1:0]   hot_reg;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
        idx = CW'((int'(rr_ptr_reg) + i) % N_CH);
        if (!found && (count_reg[idx][gi] != '0)) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end

    assign load = !valid_reg || d_req_ready[gi];
    assign head = mem_reg[win][gi][rd_ptr_reg[win][gi]];
    assign pop_flat[gi*N_CH +: N_CH] = (load && found) ? (N_CH'(1) << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg  <= 1'b0;
        data_reg   <= '0;
        wbuf_reg   <= '0;
        hot_reg    <= '0;
        rr_ptr_reg <= CW'(N_CH - 1);
      end else if (load) begin
        valid_reg <= found;
        if (found) begin
          data_reg   <= head[EW-1:WBUF_W];
          wbuf_reg   <= head[WBUF_W-1:0];
          hot_reg    <= N_CH'(1) << win;
          rr_ptr_reg <= win;
        end
      end
    end

    assign d_req_valid[gi]                  = valid_reg;
    assign d_req[gi*REQ_W +: REQ_W]         = data_reg;
    assign d_req_wbuf_id[gi*WBUF_W +: WBUF_W] = wbuf_reg;
    assign d_req_ch_1hot[gi*N_CH +: N_CH]   = hot_reg;
  end

  always_comb begin
    idle = (d_req_valid == '0);
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < N_BANK; b++) begin
        if (count_reg[c][b] != '0) idle = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xbar_voq_core.sv
// Bench for xbar_voq_core: per-cycle queue model plus directed corner sequences.
module tb_xbar_voq_core;
  localparam int N_CH = 3, N_BANK = 4, DEPTH = 8, REQ_W = 64, BANK_LSB = 6, WBUF_W = 4;
  localparam int EW = REQ_W + WBUF_W;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0]          u_req_valid;
  logic [N_CH-1:0]          u_req_ready;
  logic [N_CH*REQ_W-1:0]    u_req;
  logic [N_CH*WBUF_W-1:0]   u_req_wbuf_id;
  logic [N_BANK-1:0]        d_req_valid;
  logic [N_BANK-1:0]        d_req_ready;
  logic [N_BANK*REQ_W-1:0]  d_req;
  logic [N_BANK*WBUF_W-1:0] d_req_wbuf_id;
  logic [N_BANK*N_CH-1:0]   d_req_ch_1hot;
  logic                     idle;

  always #5 clk = ~clk;

  xbar_voq_core #(.N_CH(N_CH), .N_BANK(N_BANK), .DEPTH(DEPTH), .REQ_W(REQ_W),
                  .BANK_LSB(BANK_LSB), .WBUF_W(WBUF_W)) dut (
    .clk(clk), .rst(rst),
    .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req(u_req),
    .u_req_wbuf_id(u_req_wbuf_id),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req(d_req),
    .d_req_wbuf_id(d_req_wbuf_id), .d_req_ch_1hot(d_req_ch_1hot), .idle(idle)
  );

  int total = 0;
  int bad = 0;
  int serial = 0;

  // Reference: plain FIFOs per (channel, bank) and one output slot per bank.
  logic [EW-1:0] mq [N_CH][N_BANK][$];
  bit            mv   [N_BANK];
  logic [EW-1:0] mdat [N_BANK];
  int            msrc [N_BANK];
  int            mrr  [N_BANK];

  typedef struct {
    bit push; int ch; int bank; int wbuf; bit rdy;
    bit exp_v; logic [2:0] exp_hot; logic [3:0] exp_w; bit exp_idle;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bank_of(input int c);
    return int'(u_req[c*REQ_W + BANK_LSB +: 2]);
  endfunction

  function automatic bit model_ready(input int c);
    return !rst && (mq[c][bank_of(c)].size() < DEPTH);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < N_BANK; b++) mq[c][b].delete();
    for (int b = 0; b < N_BANK; b++) begin
      mv[b] = 0; mrr[b] = N_CH - 1; msrc[b] = 0; mdat[b] = '0;
    end
  endtask

  task automatic set_req(input int c, input int b, input int w);
    logic [REQ_W-1:0] p;
    serial++;
    p = {32'(serial), 32'($urandom)};
    p[BANK_LSB +: 2] = 2'(b);
    u_req[c*REQ_W +: REQ_W] = p;
    u_req_wbuf_id[c*WBUF_W +: WBUF_W] = 4'(w);
    u_req_valid[c] = 1'b1;
  endtask

  task automatic model_step();
    bit acc [N_CH];
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N_CH; k++) acc[k] = u_req_valid[k] && model_ready(k);
    for (int b = 0; b < N_BANK; b++) begin
      if (!mv[b] || d_req_ready[b]) begin
        mv[b] = 0;
        for (int i = 1; i <= N_CH; i++) begin
          c = (mrr[b] + i) % N_CH;
          if (!mv[b] && mq[c][b].size() > 0) begin
            mdat[b] = mq[c][b].pop_front();
            msrc[b] = c; mrr[b] = c; mv[b] = 1;
          end
        end
      end
    end
    for (int k = 0; k < N_CH; k++)
      if (acc[k])
        mq[k][bank_of(k)].push_back({u_req[k*REQ_W +: REQ_W], u_req_wbuf_id[k*WBUF_W +: WBUF_W]});
  endtask

  task automatic compare_outputs();
    bit exp_idle;
    exp_idle = 1;
    for (int b = 0; b < N_BANK; b++) begin
      check($sformatf("d_valid_b%0d", b), d_req_valid[b], mv[b]);
      if (mv[b]) begin
        exp_idle = 0;
        check($sformatf("d_req_b%0d", b),
              {d_req[b*REQ_W +: REQ_W], d_req_wbuf_id[b*WBUF_W +: WBUF_W]}, mdat[b]);
        check($sformatf("d_hot_b%0d", b), d_req_ch_1hot[b*N_CH +: N_CH], 3'b001 << msrc[b]);
      end
    end
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < N_BANK; b++)
        if (mq[c][b].size() > 0) exp_idle = 0;
    check("idle", idle, exp_idle);
  endtask

  // Called with inputs already applied; returns one clock later, #1 after the edge.
  task automatic cycle();
    #1;
    for (int c = 0; c < N_CH; c++)
      check($sformatf("u_ready_ch%0d", c), u_req_ready[c], model_ready(c));
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic fill(input int c, input int b, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      set_req(c, b, k);
      #1;
      if (!u_req_ready[c]) break;
      n++;
      cycle();
    end
    u_req_valid[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int g [$];
    int n, pushed, popped;
    bit will_push;
    logic [REQ_W-1:0] save;

    u_req_valid = '0; u_req = '0; u_req_wbuf_id = '0; d_req_ready = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_valid", d_req_valid, 4'h0);
    check("rst_d_req", d_req, '0);
    check("rst_d_wbuf", d_req_wbuf_id, '0);
    check("rst_d_hot", d_req_ch_1hot, '0);
    check("rst_u_ready", u_req_ready, 3'b000);
    rst = 1'b0;
    #1;
    check("post_rst_u_ready", u_req_ready, 3'b111);
    check("post_rst_idle", idle, 1'b1);

    // Single push ch0 -> bank 2, wbuf 5; bank held for one cycle, then accepted.
    tbl[0] = '{1, 0, 2, 5, 0, 0, 3'b000, 4'h0, 0};
    tbl[1] = '{0, 0, 2, 0, 0, 1, 3'b001, 4'h5, 0};
    tbl[2] = '{0, 0, 2, 0, 0, 1, 3'b001, 4'h5, 0};
    tbl[3] = '{0, 0, 2, 0, 1, 0, 3'b000, 4'h0, 1};
    tbl[4] = '{0, 0, 2, 0, 1, 0, 3'b000, 4'h0, 1};
    for (int i = 0; i < 5; i++) begin
      u_req_valid = '0;
      if (tbl[i].push) set_req(tbl[i].ch, tbl[i].bank, tbl[i].wbuf);
      d_req_ready = '0;
      d_req_ready[tbl[i].bank] = tbl[i].rdy;
      cycle();
      check($sformatf("tbl%0d_valid", i), d_req_valid[2], tbl[i].exp_v);
      if (tbl[i].exp_v) begin
        check($sformatf("tbl%0d_hot", i), d_req_ch_1hot[2*N_CH +: N_CH], tbl[i].exp_hot);
        check($sformatf("tbl%0d_wbuf", i), d_req_wbuf_id[2*WBUF_W +: WBUF_W], tbl[i].exp_w);
      end
      check($sformatf("tbl%0d_idle", i), idle, tbl[i].exp_idle);
    end

    // Three channels contend for bank 1: grants rotate 0,1,2.
    d_req_ready = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < N_CH; c++) set_req(c, 1, k);
      cycle();
      if (d_req_valid[1]) g.push_back(int'(d_req_ch_1hot[N_CH +: N_CH]));
    end
    u_req_valid = '0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (d_req_valid[1]) g.push_back(int'(d_req_ch_1hot[N_CH +: N_CH]));
    end
    check("rr_grant_count", g.size(), 18);
    for (int i = 0; i < g.size(); i++)
      check($sformatf("rr_grant%0d", i), g[i], 1 << (i % 3));

    // Stalled bank 3: DEPTH in the VOQ plus one in the output register.
    d_req_ready = '0;
    fill(1, 3, n);
    check("stall_accepted", n, DEPTH + 1);
    save = d_req[3*REQ_W +: REQ_W];
    repeat (3) cycle();
    check("stall_valid", d_req_valid[3], 1'b1);
    check("stall_stable", d_req[3*REQ_W +: REQ_W], save);
    set_req(1, 3, 0);
    u_req_valid[1] = 1'b0;
    d_req_ready = 4'b1000;
    cycle();
    check("resume_ready", u_req_ready[1], 1'b1);
    d_req_ready = '0;

    // Ch0 full toward bank 0 still reaches bank 1.
    fill(0, 0, n);
    check("fill_b0_accepted", n, DEPTH + 1);
    set_req(0, 1, 7);
    #1;
    check("other_bank_ready", u_req_ready[0], 1'b1);
    d_req_ready = 4'b0010;
    cycle();
    u_req_valid = '0;
    cycle();
    check("other_bank_valid", d_req_valid[1], 1'b1);
    check("other_bank_hot", d_req_ch_1hot[N_CH +: N_CH], 3'b001);
    check("b0_still_stalled", d_req_valid[0], 1'b1);

    d_req_ready = '1;
    repeat (30) cycle();
    check("drained_idle", idle, 1'b1);

    // Wrap one VOQ three times with random downstream ready.
    pushed = 0; popped = 0;
    for (int k = 0; k < 150; k++) begin
      u_req_valid = '0;
      if (pushed < 3*DEPTH) set_req(2, 0, k);
      d_req_ready = 4'b1110;
      d_req_ready[0] = 1'($urandom_range(0, 1));
      #1;
      will_push = u_req_valid[2] && u_req_ready[2];
      if (d_req_valid[0] && d_req_ready[0]) popped++;
      cycle();
      if (will_push) pushed++;
    end
    check("wrap_pushed", pushed, 3*DEPTH);
    check("wrap_popped", popped, 3*DEPTH);

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      u_req_valid = '0;
      for (int c = 0; c < N_CH; c++) begin
        set_req(c, $urandom_range(0, N_BANK-1), $urandom_range(0, 15));
        u_req_valid[c] = 1'($urandom_range(0, 1));
      end
      d_req_ready = 4'($urandom);
      cycle();
    end

    // Reset in the middle of traffic.
    d_req_ready = '0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < N_CH; c++) set_req(c, (k + c) % N_BANK, k);
      cycle();
    end
    check("pre_rst_valid", d_req_valid, 4'hF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", d_req_valid, 4'h0);
    check("mid_rst_ready", u_req_ready, 3'b000);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    u_req_valid = '0;
    #1;
    check("rel_rst_idle", idle, 1'b1);
    d_req_ready = '1;
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
